// File: rtl/gain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gain_ctrl_pkg
// Description : Shared types, direction encodings and the one-hot gain decode
//               for the adaptive loop-gain controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gain_ctrl_pkg;

  // Phase-detector / decision direction encoding
  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  // Widest gain index the decode helper supports; callers narrow the result
  localparam int MAX_ALPHA_W  = 8;
  localparam int MAX_LAMBDA_W = 2 ** MAX_ALPHA_W;

  // Lock tracking states
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // One-hot decode of a gain index: bit 'a' set, all others clear
  function automatic logic [MAX_LAMBDA_W-1:0] onehot_decode(input logic [MAX_ALPHA_W-1:0] a);
    logic [MAX_LAMBDA_W-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gain_window_vote.sv
`default_nettype none
// ============================================================================
// Module      : gain_window_vote
// Description : Counts enabled samples over a 2**WIN_LOG2 window, accumulates
//               lead samples and flags the majority vote at window end.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_window_vote #(
  parameter int WIN_LOG2 = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic lead_lag,
  output logic win_end,
  output logic vote_lead,
  output logic vote_lag,
  output logic tie
);

  localparam int                ACC_W    = WIN_LOG2 + 1;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [ACC_W-1:0]  HALF     = ACC_W'(2 ** (WIN_LOG2 - 1));

  logic [WIN_LOG2-1:0] win_cnt;
  logic [ACC_W-1:0]    lead_acc;
  logic [ACC_W-1:0]    tot;

  // The closing sample is folded into the total so it counts toward the vote
  assign win_end   = en & (win_cnt == CNT_LAST);
  assign tot       = lead_acc + {{WIN_LOG2{1'b0}}, lead_lag};
  assign vote_lead = win_end & (tot > HALF);
  assign vote_lag  = win_end & (tot < HALF);
  assign tie       = win_end & (tot == HALF);

  // Window counter and lead accumulator; frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      lead_acc <= '0;
    end else if (clear) begin
      win_cnt  <= '0;
      lead_acc <= '0;
    end else if (en) begin
      if (win_end) begin
        win_cnt  <= '0;
        lead_acc <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        lead_acc <= tot;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adaptive_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adaptive_gain_ctrl
// Description : Loop-gain controller for the DLL/ADPLL loop filter. Steps a
//               saturating gain index from windowed phase-detector votes and
//               tracks lock from direction reversals.
// Revision    : 1.0 - initial release
// ============================================================================
module adaptive_gain_ctrl
  import gain_ctrl_pkg::*;
#(
  parameter int WIN_LOG2   = 4,
  parameter int ALPHA_W    = 3,
  parameter int ALPHA_INIT = 7,
  parameter int LOCK_CNT   = 2,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    restart,
  input  logic                    lead_lag,
  output logic [(2**ALPHA_W)-1:0] lambda,
  output logic [ALPHA_W-1:0]      alpha,
  output logic                    lock,
  output logic                    dec_valid,
  output logic                    dec_lead
);

  localparam int                 LAMBDA_W  = 2 ** ALPHA_W;
  localparam int                 REV_W     = $clog2(LOCK_CNT + 1);
  localparam int                 SAME_W    = $clog2(UNLOCK_CNT + 1);
  localparam logic [ALPHA_W-1:0] ALPHA_MAX = '1;
  localparam logic [ALPHA_W-1:0] ALPHA_RST = ALPHA_W'(ALPHA_INIT);
  localparam logic [REV_W-1:0]   REV_SAT   = REV_W'(LOCK_CNT);
  localparam logic [SAME_W-1:0]  SAME_SAT  = SAME_W'(UNLOCK_CNT);

  logic win_end, vote_lead, vote_lag, tie;
  logic decide, dir;

  lock_state_t       state, state_nxt;
  logic [ALPHA_W-1:0] alpha_nxt;
  logic [REV_W-1:0]  rev_cnt, rev_nxt;
  logic [SAME_W-1:0] same_cnt, same_nxt;
  logic              last_dir_vld, vld_nxt;
  logic              dv_nxt, dl_nxt;

  gain_window_vote #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_vote (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .en        (en),
    .lead_lag  (lead_lag),
    .win_end   (win_end),
    .vote_lead (vote_lead),
    .vote_lag  (vote_lag),
    .tie       (tie)
  );

  // A tied window produces no decision and leaves all state untouched
  assign decide = win_end & ~tie & (vote_lead | vote_lag);
  assign dir    = vote_lead ? DIR_LEAD : DIR_LAG;

  assign lock   = (state == LOCK_HELD);
  assign lambda = LAMBDA_W'(onehot_decode(MAX_ALPHA_W'(alpha)));

  // Next-state: gain step, reversal/drift counters and lock transitions
  always_comb begin
    alpha_nxt = alpha;
    state_nxt = state;
    rev_nxt   = rev_cnt;
    same_nxt  = same_cnt;
    vld_nxt   = last_dir_vld;
    dv_nxt    = 1'b0;
    dl_nxt    = dec_lead;
    if (decide) begin
      dv_nxt = 1'b1;
      dl_nxt = dir;
      if (dir == DIR_LEAD) begin
        if (alpha != ALPHA_MAX) alpha_nxt = alpha + 1'b1;
      end else begin
        if (alpha != '0) alpha_nxt = alpha - 1'b1;
      end
      if (!last_dir_vld) begin
        // First decision only establishes a reference direction
        vld_nxt = 1'b1;
      end else if (dir != dec_lead) begin
        same_nxt = '0;
        if (rev_cnt != REV_SAT) rev_nxt = rev_cnt + 1'b1;
        if (int'(rev_cnt) + 1 >= LOCK_CNT) state_nxt = LOCK_HELD;
      end else begin
        rev_nxt = '0;
        if (same_cnt != SAME_SAT) same_nxt = same_cnt + 1'b1;
        if ((state == LOCK_HELD) && (int'(same_cnt) + 1 >= UNLOCK_CNT)) begin
          state_nxt = LOCK_IDLE;
          same_nxt  = '0;
        end
      end
    end
  end

  // State register; restart clears everything and discards this cycle's sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha        <= ALPHA_RST;
      state        <= LOCK_IDLE;
      rev_cnt      <= '0;
      same_cnt     <= '0;
      last_dir_vld <= 1'b0;
      dec_valid    <= 1'b0;
      dec_lead     <= 1'b0;
    end else if (restart) begin
      alpha        <= ALPHA_RST;
      state        <= LOCK_IDLE;
      rev_cnt      <= '0;
      same_cnt     <= '0;
      last_dir_vld <= 1'b0;
      dec_valid    <= 1'b0;
      dec_lead     <= 1'b0;
    end else begin
      alpha        <= alpha_nxt;
      state        <= state_nxt;
      rev_cnt      <= rev_nxt;
      same_cnt     <= same_nxt;
      last_dir_vld <= vld_nxt;
      dec_valid    <= dv_nxt;
      dec_lead     <= dl_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adaptive_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adaptive_gain_ctrl
// Description : Directed self-checking bench for adaptive_gain_ctrl with
//               default parameters (16-sample window, 3-bit gain index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adaptive_gain_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic       lead_lag;
  logic [7:0] lambda;
  logic [2:0] alpha;
  logic       lock;
  logic       dec_valid;
  logic       dec_lead;

  int errors = 0;
  int checks = 0;

  adaptive_gain_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .lead_lag  (lead_lag),
    .lambda    (lambda),
    .alpha     (alpha),
    .lock      (lock),
    .dec_valid (dec_valid),
    .dec_lead  (dec_lead)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and land 1 time unit after the rising edge
  task automatic step(input logic e, input logic ll, input logic rs);
    en       = e;
    lead_lag = ll;
    restart  = rs;
    @(posedge clk);
    #1;
  endtask

  // One full enabled window: 'ones' leading samples first, then lag samples
  task automatic run_win(input int ones);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < ones), 1'b0);
      if (i < 15) chk("dv_idle_in_window", {31'd0, dec_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    lead_lag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    chk("rst_alpha",     {29'd0, alpha}, 32'd7);
    chk("rst_lambda",    {24'd0, lambda}, 32'h80);
    chk("rst_lock",      {31'd0, lock}, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_dec_lead",  {31'd0, dec_lead}, 32'd0);

    // 2: all-lag windows walk alpha to 0 and saturate there
    run_win(0);
    chk("lag1_dv",     {31'd0, dec_valid}, 32'd1);
    chk("lag1_alpha",  {29'd0, alpha}, 32'd6);
    chk("lag1_lambda", {24'd0, lambda}, 32'h40);
    chk("lag1_dir",    {31'd0, dec_lead}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("lag1_pulse_end", {31'd0, dec_valid}, 32'd0);
    for (int w = 2; w <= 7; w++) begin
      run_win(0);
      chk("lag_walk_alpha", {29'd0, alpha}, 32'(7 - w));
    end
    chk("lag7_lambda", {24'd0, lambda}, 32'h01);
    run_win(0);
    chk("lag_sat_dv",    {31'd0, dec_valid}, 32'd1);
    chk("lag_sat_alpha", {29'd0, alpha}, 32'd0);
    chk("lag_sat_lock",  {31'd0, lock}, 32'd0);

    step(1'b0, 1'b0, 1'b1);
    chk("rs1_alpha", {29'd0, alpha}, 32'd7);

    // 3: LAG, LEAD, LAG -> lock on the second reversal
    run_win(0);
    chk("rev_a_alpha", {29'd0, alpha}, 32'd6);
    chk("rev_a_lock",  {31'd0, lock}, 32'd0);
    run_win(16);
    chk("rev_b_alpha", {29'd0, alpha}, 32'd7);
    chk("rev_b_dir",   {31'd0, dec_lead}, 32'd1);
    chk("rev_b_lock",  {31'd0, lock}, 32'd0);
    run_win(0);
    chk("rev_c_alpha", {29'd0, alpha}, 32'd6);
    chk("rev_c_lock",  {31'd0, lock}, 32'd1);

    // 5: four same-direction decisions drop lock on the fourth
    for (int w = 1; w <= 3; w++) begin
      run_win(0);
      chk("drift_alpha", {29'd0, alpha}, 32'(6 - w));
      chk("drift_lock_held", {31'd0, lock}, 32'd1);
    end
    run_win(0);
    chk("drift4_dv",    {31'd0, dec_valid}, 32'd1);
    chk("drift4_alpha", {29'd0, alpha}, 32'd2);
    chk("drift4_lock",  {31'd0, lock}, 32'd0);

    // 4: exact tie makes no decision; one extra lead sample tips it
    run_win(8);
    chk("tie_dv",    {31'd0, dec_valid}, 32'd0);
    chk("tie_alpha", {29'd0, alpha}, 32'd2);
    chk("tie_lock",  {31'd0, lock}, 32'd0);
    run_win(9);
    chk("nine_dv",    {31'd0, dec_valid}, 32'd1);
    chk("nine_dir",   {31'd0, dec_lead}, 32'd1);
    chk("nine_alpha", {29'd0, alpha}, 32'd3);

    // Upper saturation
    step(1'b0, 1'b0, 1'b1);
    run_win(16);
    chk("top_sat_dv",    {31'd0, dec_valid}, 32'd1);
    chk("top_sat_alpha", {29'd0, alpha}, 32'd7);

    // 6: en low for 5 cycles mid-window; disabled lead samples must be ignored
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 21; i++) begin
      if (i <= 8)       step(1'b1, 1'b0, 1'b0);
      else if (i <= 13) step(1'b0, 1'b1, 1'b0);
      else if (i == 14) step(1'b1, 1'b0, 1'b0);
      else              step(1'b1, 1'b1, 1'b0);
      if (i < 21) chk("slip_dv_idle", {31'd0, dec_valid}, 32'd0);
    end
    chk("slip_dv",    {31'd0, dec_valid}, 32'd1);
    chk("slip_dir",   {31'd0, dec_lead}, 32'd0);
    chk("slip_alpha", {29'd0, alpha}, 32'd6);

    // restart on the 8th enabled cycle of the next window wins over en
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_rs_alpha", {29'd0, alpha}, 32'd7);
    chk("mid_rs_lock",  {31'd0, lock}, 32'd0);
    chk("mid_rs_dv",    {31'd0, dec_valid}, 32'd0);
    run_win(0);
    chk("post_rs_dv",    {31'd0, dec_valid}, 32'd1);
    chk("post_rs_alpha", {29'd0, alpha}, 32'd6);

    // Async reset mid-window clears immediately and discards the partial window
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_alpha",  {29'd0, alpha}, 32'd7);
    chk("async_lambda", {24'd0, lambda}, 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    run_win(0);
    chk("post_rst_dv",    {31'd0, dec_valid}, 32'd1);
    chk("post_rst_alpha", {29'd0, alpha}, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
